// File: rtl/dram_access_sequencer.sv
// dram_access_sequencer: walks a strided burst of DRAM requests
// (address/write_en/req_valid) and tracks read-return latency (rd_valid).
// Ports: clk, rst_n (async low); command start/op_write/base_addr/stride/
// length; stall back-pressure; request address/write_en/req_valid;
// rd_valid; progress issued/busy/done.
module dram_access_sequencer #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 9,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op_write,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic [LEN_W-1:0]  length,
   input  logic              stall,
   output logic [ADDR_W-1:0] address,
   output logic              write_en,
   output logic              req_valid,
   output logic              rd_valid,
   output logic [LEN_W-1:0]  issued,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] stride_q;
   logic [ADDR_W-1:0] last_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic              op_q;
   logic              done_q;
   logic [2:0]        drain_q;
   logic [RD_LAT-1:0] rd_sr;
   logic              fire;
   logic              last;

   // A request goes out only in ISSUE and only when not stalled.
   assign fire      = (state == ISSUE) && !stall;
   assign last      = (cnt_q + 1'b1) == len_q;
   assign req_valid = fire;
   assign write_en  = fire & op_q;
   // Outside a live request the address shows the last one issued.
   assign address   = fire ? addr_q : last_q;
   assign issued    = cnt_q;
   assign busy      = (state != IDLE);
   assign done      = done_q;
   assign rd_valid  = rd_sr[RD_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         last_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         done_q   <= 1'b0;
         drain_q  <= '0;
         rd_sr    <= '0;
      end else begin
         done_q   <= 1'b0;
         rd_sr[0] <= fire & ~op_q;
         for (int i = 1; i < RD_LAT; i++) begin
            rd_sr[i] <= rd_sr[i-1];
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     addr_q   <= base_addr;
                     stride_q <= stride;
                     len_q    <= length;
                     op_q     <= op_write;
                     cnt_q    <= '0;
                     state    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (fire) begin
                  last_q <= addr_q;
                  addr_q <= addr_q + stride_q;
                  cnt_q  <= cnt_q + 1'b1;
                  if (last) begin
                     if (op_q) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                     end else begin
                        drain_q <= 3'(RD_LAT - 1);
                        state   <= DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               // Hold until the final read's rd_valid cycle has passed.
               if (drain_q == '0) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  drain_q <= drain_q - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_access_sequencer.sv
// tb_dram_access_sequencer: directed stimulus with immediate assertions
// against hand-computed request streams for dram_access_sequencer.
module tb_dram_access_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       op_write;
   logic [7:0] base_addr;
   logic [7:0] stride;
   logic [8:0] length;
   logic       stall;
   logic [7:0] address;
   logic       write_en;
   logic       req_valid;
   logic       rd_valid;
   logic [8:0] issued;
   logic       busy;
   logic       done;

   int n_chk  = 0;
   int n_fail = 0;

   dram_access_sequencer #(
      .ADDR_W(8),
      .LEN_W (9),
      .RD_LAT(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_write (op_write),
      .base_addr(base_addr),
      .stride   (stride),
      .length   (length),
      .stall    (stall),
      .address  (address),
      .write_en (write_en),
      .req_valid(req_valid),
      .rd_valid (rd_valid),
      .issued   (issued),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packed view: {address, write_en, req_valid, rd_valid, busy, done}
   function automatic logic [31:0] outs;
      return {19'd0, address, write_en, req_valid, rd_valid, busy, done};
   endfunction

   function automatic logic [31:0] exp_o(input logic [7:0] a, input logic w,
                                          input logic r, input logic rv,
                                          input logic b, input logic d);
      return {19'd0, a, w, r, rv, b, d};
   endfunction

   task automatic cmd(input logic w, input logic [7:0] b,
                      input logic [7:0] s, input logic [8:0] l);
      op_write  = w;
      base_addr = b;
      stride    = s;
      length    = l;
      start     = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op_write = 1'b0;
      base_addr = '0;
      stride = '0;
      length = '0;
      stall = 1'b0;
      #12;
      rst_n = 1'b1;

      // Reset / idle
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle", outs(), exp_o(8'h00, 0, 0, 0, 0, 0));
      end
      stall = 1'b1;
      #1;
      chk("idle_stall", outs(), exp_o(8'h00, 0, 0, 0, 0, 0));
      stall = 1'b0;

      // Write burst 0x05 stride 1 length 4
      cmd(1'b1, 8'h05, 8'h01, 9'd4);
      for (int i = 0; i < 4; i++) begin
         chk("wr_req", outs(), exp_o(8'(8'h05 + i), 1, 1, 0, 1, 0));
         tick();
      end
      chk("wr_done", outs(), exp_o(8'h08, 0, 0, 0, 1, 1));
      chk("wr_issued", 32'(issued), 32'd4);
      tick();
      chk("wr_after", outs(), exp_o(8'h08, 0, 0, 0, 0, 0));

      // Read burst 0x40 stride 0x10 length 3, stall on 2nd issue cycle
      cmd(1'b0, 8'h40, 8'h10, 9'd3);
      chk("rd_c1", outs(), exp_o(8'h40, 0, 1, 0, 1, 0));
      tick();
      stall = 1'b1;
      #1;
      chk("rd_c2_stall", 32'({write_en, req_valid, rd_valid, busy}), 32'b0001);
      chk("rd_c2_issued", 32'(issued), 32'd1);
      tick();
      stall = 1'b0;
      #1;
      chk("rd_c3", outs(), exp_o(8'h50, 0, 1, 1, 1, 0));
      tick();
      chk("rd_c4", outs(), exp_o(8'h60, 0, 1, 0, 1, 0));
      tick();
      chk("rd_c5", outs(), exp_o(8'h60, 0, 0, 1, 1, 0));
      tick();
      chk("rd_c6", outs(), exp_o(8'h60, 0, 0, 1, 1, 0));
      tick();
      chk("rd_done", outs(), exp_o(8'h60, 0, 0, 0, 1, 1));
      chk("rd_issued", 32'(issued), 32'd3);
      tick();
      chk("rd_after", outs(), exp_o(8'h60, 0, 0, 0, 0, 0));

      // Address wrap
      cmd(1'b1, 8'hFE, 8'h01, 9'd3);
      chk("wrap0", outs(), exp_o(8'hFE, 1, 1, 0, 1, 0));
      tick();
      chk("wrap1", outs(), exp_o(8'hFF, 1, 1, 0, 1, 0));
      tick();
      chk("wrap2", outs(), exp_o(8'h00, 1, 1, 0, 1, 0));
      tick();
      chk("wrap_done", outs(), exp_o(8'h00, 0, 0, 0, 1, 1));
      tick();

      // Zero length: done pulse only
      cmd(1'b1, 8'h33, 8'h01, 9'd0);
      chk("zero_done", outs(), exp_o(8'h00, 0, 0, 0, 0, 1));
      tick();
      chk("zero_after", outs(), exp_o(8'h00, 0, 0, 0, 0, 0));

      // Start while busy is ignored
      cmd(1'b1, 8'h10, 8'h02, 9'd4);
      start = 1'b1;
      base_addr = 8'h80;
      stride = 8'h07;
      length = 9'd1;
      op_write = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("busy_req", outs(), exp_o(8'(8'h10 + 2 * i), 1, 1, 0, 1, 0));
         tick();
      end
      start = 1'b0;
      #1;
      chk("busy_done", outs(), exp_o(8'h16, 0, 0, 0, 1, 1));
      tick();

      // Reset in the middle of a length-8 read
      cmd(1'b0, 8'h00, 8'h01, 9'd8);
      tick();
      tick();
      chk("mid_pre", outs(), exp_o(8'h02, 0, 1, 1, 1, 0));
      rst_n = 1'b0;
      #1;
      chk("mid_rst", outs(), exp_o(8'h00, 0, 0, 0, 0, 0));
      chk("mid_rst_iss", 32'(issued), 32'd0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst", outs(), exp_o(8'h00, 0, 0, 0, 0, 0));
      end
      cmd(1'b1, 8'h20, 8'h03, 9'd2);
      chk("new0", outs(), exp_o(8'h20, 1, 1, 0, 1, 0));
      tick();
      chk("new1", outs(), exp_o(8'h23, 1, 1, 0, 1, 0));
      tick();
      chk("new_done", outs(), exp_o(8'h23, 0, 0, 0, 1, 1));
      chk("new_issued", 32'(issued), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dram_access_sequencer.md
Name: dram_access_sequencer

Overview:
- Initiator side of the DRAM bank-decode interface.
- Generates the `address`/`write_en` request stream that the DRAM controller decodes into bank enables.
- Walks a strided block of matrix elements (rows, columns, tiles) for one read or write burst per command.
- Tracks read-return latency and flags returning read data. Reports busy/done to the matrix-multiply control FSM.

Parameters:
ADDR_W, 8, width of DRAM address (256 words; address wraps modulo 2^ADDR_W)
LEN_W, 9, width of burst length (max 256 accesses)
RD_LAT, 2, cycles from read issue to read data valid at DRAM output (1..4)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe, sampled only in IDLE
op_write  input  1  command type: 1 = write burst, 0 = read burst
base_addr  input  ADDR_W  first address of burst
stride  input  ADDR_W  address increment per access (0 allowed: repeat same word)
length  input  LEN_W  number of accesses (0..256)
stall  input  1  downstream back-pressure; no request issued in a cycle where high
address  output  ADDR_W  request address to DRAM controller
write_en  output  1  write strobe to DRAM controller
req_valid  output  1  request present this cycle
rd_valid  output  1  read data for an earlier read request is valid this cycle
issued  output  LEN_W  number of requests issued in current burst
busy  output  1  burst in progress
done  output  1  one-cycle pulse at end of burst

Behaviour:
- Reset:
  - Asynchronous on rst_n low; takes effect immediately, including mid-burst.
  - All outputs 0 and FSM to IDLE.
  - Read-latency pipeline cleared, so no stray rd_valid after reset release.
- FSM states:
  - IDLE: busy=0, req_valid=0, write_en=0, address holds last value (0 after reset).
    - start=1 and length!=0: latch base_addr, stride, length, op_write; clear issued; go ISSUE.
    - start=1 and length==0: done=1 next cycle; stay IDLE; no request.
  - ISSUE: busy=1.
    - Each cycle with stall=0: req_valid=1, address=current addr, write_en=latched op_write; next addr = addr+stride mod 2^ADDR_W; issued increments.
    - stall=1: req_valid=0, write_en=0, address and issued held.
    - After the request that makes issued==length: write burst goes DONE; read burst goes DRAIN.
  - DRAIN: busy=1, req_valid=0. Waits until the last read's rd_valid has been produced, i.e. RD_LAT cycles after the last issue. Then go DONE.
  - DONE: done=1 for exactly one cycle, busy=1 this cycle; next state IDLE (busy=0).
- Latency:
  - start sampled at edge k → first req_valid during cycle k+1.
  - Burst of N with no stalls and op_write=1: req_valid high N consecutive cycles; done on cycle k+N+1.
- Invariants:
  - write_en never high without req_valid.
  - Stall has no effect outside ISSUE.
- rd_valid: equals (req_valid & ~write_en) delayed exactly RD_LAT cycles through a shift register. It is independent of stall after issue.
- start while busy=1: ignored; latched command unchanged.
- Changes to base_addr, stride, length, op_write after start: no effect on current burst.
- Address wrap: base 0xFE, stride 1 produces 0xFE, 0xFF, 0x00, ... with no error.
- length=256: issued reaches 256 (needs LEN_W=9); no overflow.

Test Plan:
- Reset/idle: rst_n low then high, no start for 10 cycles → address=0, write_en=0, req_valid=0, rd_valid=0, busy=0, done=0 throughout.
- Write burst: base 0x05, stride 1, length 4, op_write=1, no stall → addresses 0x05,0x06,0x07,0x08 on 4 consecutive cycles with write_en=1; done pulse on the next cycle; issued=4.
- Read burst with stall: base 0x40, stride 0x10, length 3, op_write=0, stall high on 2nd issue cycle → addresses 0x40,(gap),0x50,0x60; write_en=0; rd_valid high RD_LAT=2 cycles after each issue; done only after the third rd_valid.
- Wrap and zero length: base 0xFE, stride 1, length 3 → 0xFE,0xFF,0x00. Then start with length 0 → done pulse, no req_valid.
- Start while busy: second start mid-burst with different base → ignored; original sequence completes unchanged.
- Reset mid-burst: rst_n low during 3rd request of a length-8 read → outputs 0 immediately; no rd_valid after release; a new start then behaves normally.
